irq_ctrl: RTL

Interrupt controller that sits between the peripheral IRQ sources (timer, UART, GPIO) and the core's single external-interrupt input. It latches one-cycle source pulses into sticky pending bits and masks them with a software enable register. It presents one level interrupt to the core and arbitrates by fixed priority (lowest index wins). Software services interrupts through a claim/complete register handshake on the same CE/REQ/GNT peripheral bus used by the other memory-mapped blocks.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller:
// register offsets, FSM encoding and ID constants.
package irq_pkg;

   localparam int ID_W = 5;

   localparam logic [1:0] ADDR_PENDING  = 2'd0;
   localparam logic [1:0] ADDR_ENABLE   = 2'd1;
   localparam logic [1:0] ADDR_CLAIM    = 2'd2;
   localparam logic [1:0] ADDR_COMPLETE = 2'd3;

   localparam logic [ID_W-1:0] ID_NONE = '0;

   typedef enum logic {
      ST_IDLE,
      ST_INSVC
   } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; source i maps to ID i+1.
// ID 0 (with valid low) means no request.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]    req,
   output logic            valid,
   output logic [ID_W-1:0] id
);

   always_comb begin
      valid = 1'b0;
      id    = ID_NONE;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            id    = ID_W'(i + 1);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: sticky pending bits, enable mask, fixed
// priority and a claim/complete handshake over the CE/REQ/GNT bus.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int N_SRC = 4
) (
   input  logic             i_CLK,
   input  logic             i_RSTn,
   input  logic             i_CE,
   input  logic             i_REQ,
   input  logic             i_WE,
   input  logic [1:0]       i_ADDR,
   input  logic [31:0]      i_WDATA,
   output logic [31:0]      o_RDATA,
   output logic             o_GNT,
   input  logic [N_SRC-1:0] i_SRC,
   output logic             o_IRQ
);

   state_t            state_q, state_d;
   logic [N_SRC-1:0]  pend_q, en_q;
   logic [ID_W-1:0]   insvc_q, insvc_d;
   logic              irq_d;
   logic              acc, wr, rd;
   logic              claim_go;
   logic              win_valid;
   logic [ID_W-1:0]   win_id;
   logic [N_SRC-1:0]  clr;
   logic              unused_ok;

   assign acc   = i_REQ & i_CE;
   assign wr    = acc & i_WE;
   assign rd    = acc & ~i_WE;
   assign o_GNT = acc;

   assign unused_ok = &{1'b0, i_WDATA[31:N_SRC]};

   irq_prio_enc #(
      .N     (N_SRC)
   ) u_prio (
      .req   (pend_q & en_q),
      .valid (win_valid),
      .id    (win_id)
   );

   always_comb begin
      state_d  = state_q;
      insvc_d  = insvc_q;
      irq_d    = 1'b0;
      claim_go = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rd && i_ADDR == ADDR_CLAIM && win_valid) begin
               claim_go = 1'b1;
               state_d  = ST_INSVC;
               insvc_d  = win_id;
            end
            irq_d = win_valid & ~claim_go;
         end
         ST_INSVC: begin
            if (wr && i_ADDR == ADDR_COMPLETE &&
                i_WDATA[ID_W-1:0] == insvc_q) begin
               state_d = ST_IDLE;
               insvc_d = ID_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Clear sources: software W1C plus the bit taken by a claim
   always_comb begin
      clr = '0;
      if (wr && i_ADDR == ADDR_PENDING)
         clr = i_WDATA[N_SRC-1:0];
      for (int i = 0; i < N_SRC; i++) begin
         if (claim_go && win_id == ID_W'(i + 1))
            clr[i] = 1'b1;
      end
   end

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state_q <= ST_IDLE;
         insvc_q <= ID_NONE;
         pend_q  <= '0;
         en_q    <= '0;
         o_IRQ   <= 1'b0;
      end else begin
         state_q <= state_d;
         insvc_q <= insvc_d;
         pend_q  <= (pend_q & ~clr) | i_SRC;
         o_IRQ   <= irq_d;
         if (wr && i_ADDR == ADDR_ENABLE)
            en_q <= i_WDATA[N_SRC-1:0];
      end
   end

   always_comb begin
      o_RDATA = '0;
      unique case (i_ADDR)
         ADDR_PENDING:  o_RDATA[N_SRC-1:0] = pend_q;
         ADDR_ENABLE:   o_RDATA[N_SRC-1:0] = en_q;
         ADDR_CLAIM: begin
            if (state_q == ST_IDLE)
               o_RDATA[ID_W-1:0] = win_id;
         end
         default:       o_RDATA[ID_W-1:0] = insvc_q;
      endcase
   end

endmodule
